// File: rtl/hdmi_pkg.sv
// Shared symbol constants, TERC4 code table, link-state and symbol-class types
// for the TMDS receive decoder.
package hdmi_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] GB_PAT_A = 10'b1011001100;
    localparam logic [9:0] GB_PAT_B = 10'b0100110011;
    localparam logic [9:0] DI_GB    = GB_PAT_B;

    localparam logic [1:0] GB_LEN = 2'd2;

    typedef enum logic [2:0] {
        ST_CTRL, ST_VGB, ST_VIDEO, ST_DGB_LEAD, ST_ISLAND, ST_DGB_TRAIL
    } link_state_t;

    typedef enum logic [2:0] {
        K_ERR, K_CTRL, K_VIDEO, K_AUX, K_GB
    } sym_kind_t;

    function automatic logic [9:0] video_gb(input int ch);
        return (ch == 1) ? GB_PAT_B : GB_PAT_A;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] n);
        case (n)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    function automatic logic is_ctrl(input logic [9:0] s);
        return (s == CTRL_00) || (s == CTRL_01) || (s == CTRL_10) || (s == CTRL_11);
    endfunction

    function automatic logic [1:0] ctrl_bits(input logic [9:0] s);
        case (s)
            CTRL_01: return 2'b01;
            CTRL_10: return 2'b10;
            CTRL_11: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] b;
        logic [7:0] d;
        b    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        return d;
    endfunction

endpackage

// File: rtl/terc4_decode.sv
// Combinational TERC4 inverse lookup: flags a legal code and returns its nibble.
module terc4_decode
    import hdmi_pkg::*;
(
    input  logic [9:0] symbol,
    output logic       match,
    output logic [3:0] nibble
);

    always_comb begin
        match  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (symbol == terc4_code(4'(i))) begin
                match  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// Per-channel HDMI receive decoder: tracks the link period and decodes video, TERC4 or control.
// States: CTRL control period | VGB video guard | VIDEO pixels | DGB_LEAD island lead guard | ISLAND TERC4 | DGB_TRAIL island trail guard
module tmds_decoder
    import hdmi_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] symbol,
    input  logic       symbol_valid,
    input  logic       di_gb_in,
    output logic       di_gb_out,
    output logic       out_valid,
    output logic [7:0] pixel_component,
    output logic [3:0] aux_data,
    output logic       c0,
    output logic       c1,
    output logic       vde,
    output logic       ade,
    output logic       gb,
    output logic       code_err
);

    localparam logic       IS_CH0  = (CHANNEL == 0);
    localparam logic       IS_CH1  = (CHANNEL == 1);
    localparam logic [9:0] VGB_PAT = video_gb(CHANNEL);

    logic [9:0]  s1_sym;
    logic        s1_valid;
    logic        s1_match;
    logic [3:0]  s1_nib;
    link_state_t state;
    link_state_t nxt;
    logic [1:0]  gb_left;
    logic [1:0]  gb_nxt;
    sym_kind_t   kind;
    logic [9:0]  s2_sym;
    logic [3:0]  s2_nib;
    sym_kind_t   s2_kind;
    logic        s2_valid;

    logic is_ctl, pat_vgb, pat_dgb, vgb_hit, dgb_hit, dgb_cont;

    terc4_decode u_terc4 (
        .symbol (s1_sym),
        .match  (s1_match),
        .nibble (s1_nib)
    );

    assign di_gb_out = (CHANNEL == 2) && (s1_sym == DI_GB) && (state == ST_CTRL);

    // ch1 shares one pattern for both guard bands; ch2's same-cycle view breaks the tie.
    always_comb begin
        is_ctl   = is_ctrl(s1_sym);
        pat_vgb  = (s1_sym == VGB_PAT);
        pat_dgb  = (s1_sym == DI_GB);
        vgb_hit  = IS_CH1 ? (pat_vgb && !di_gb_in) : pat_vgb;
        dgb_hit  = IS_CH0 ? (s1_match && (s1_nib != 4'h8))
                 : IS_CH1 ? (pat_dgb && di_gb_in) : pat_dgb;
        dgb_cont = IS_CH0 ? s1_match : pat_dgb;
        kind     = K_ERR;
        nxt      = state;
        gb_nxt   = gb_left;
        case (state)
            ST_CTRL: begin
                if (is_ctl) begin
                    kind = K_CTRL;
                end else if (vgb_hit) begin
                    kind   = K_GB;
                    nxt    = ST_VGB;
                    gb_nxt = GB_LEN - 2'd1;
                end else if (dgb_hit) begin
                    kind   = IS_CH0 ? K_AUX : K_GB;
                    nxt    = ST_DGB_LEAD;
                    gb_nxt = GB_LEN - 2'd1;
                end
            end
            ST_VGB: begin
                if (pat_vgb) begin
                    kind   = K_GB;
                    gb_nxt = gb_left - 2'd1;
                    if (gb_left == 2'd1) nxt = ST_VIDEO;
                end else begin
                    nxt    = ST_CTRL;
                    gb_nxt = 2'd0;
                end
            end
            ST_VIDEO: begin
                if (is_ctl) begin
                    kind = K_CTRL;
                    nxt  = ST_CTRL;
                end else begin
                    kind = K_VIDEO;
                end
            end
            ST_DGB_LEAD: begin
                if (dgb_cont) begin
                    kind   = IS_CH0 ? K_AUX : K_GB;
                    gb_nxt = gb_left - 2'd1;
                    if (gb_left == 2'd1) nxt = ST_ISLAND;
                end else begin
                    nxt    = ST_CTRL;
                    gb_nxt = 2'd0;
                end
            end
            ST_ISLAND: begin
                if (is_ctl) begin
                    kind = K_CTRL;
                    nxt  = ST_CTRL;
                end else if (!IS_CH0 && pat_dgb) begin
                    kind   = K_GB;
                    nxt    = ST_DGB_TRAIL;
                    gb_nxt = GB_LEN - 2'd1;
                end else if (s1_match) begin
                    kind = K_AUX;
                end
            end
            ST_DGB_TRAIL: begin
                nxt = ST_CTRL;
                if (pat_dgb) begin
                    kind   = K_GB;
                    gb_nxt = gb_left - 2'd1;
                    if (gb_left != 2'd1) nxt = ST_DGB_TRAIL;
                end else begin
                    gb_nxt = 2'd0;
                end
            end
            default: begin
                nxt    = ST_CTRL;
                gb_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_sym          <= '0;
            s1_valid        <= 1'b0;
            state           <= ST_CTRL;
            gb_left         <= '0;
            s2_sym          <= '0;
            s2_nib          <= '0;
            s2_kind         <= K_ERR;
            s2_valid        <= 1'b0;
            out_valid       <= 1'b0;
            pixel_component <= '0;
            aux_data        <= '0;
            c0              <= 1'b0;
            c1              <= 1'b0;
            vde             <= 1'b0;
            ade             <= 1'b0;
            gb              <= 1'b0;
            code_err        <= 1'b0;
        end else begin
            s1_valid <= symbol_valid;
            if (symbol_valid) s1_sym <= symbol;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                state   <= nxt;
                gb_left <= gb_nxt;
                s2_sym  <= s1_sym;
                s2_nib  <= s1_nib;
                s2_kind <= kind;
            end
            out_valid <= s2_valid;
            vde       <= 1'b0;
            ade       <= 1'b0;
            gb        <= 1'b0;
            code_err  <= 1'b0;
            if (s2_valid) begin
                case (s2_kind)
                    K_CTRL:  {c1, c0} <= ctrl_bits(s2_sym);
                    K_VIDEO: begin
                        pixel_component <= tmds_decode(s2_sym);
                        vde             <= 1'b1;
                    end
                    K_AUX: begin
                        aux_data <= s2_nib;
                        ade      <= 1'b1;
                    end
                    K_GB:    gb       <= 1'b1;
                    default: code_err <= 1'b1;
                endcase
            end
        end
    end

endmodule
